// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the button debouncer slice.
// The FSM encodings stay as fixed 2-bit constants so existing decode logic
// and debug tooling that reads raw state values keep working.
package debounce_pkg;

   // Debouncer FSM encodings
   localparam logic [1:0] IDLE_LOW  = 2'd0;
   localparam logic [1:0] WAIT_HIGH = 2'd1;
   localparam logic [1:0] IDLE_HIGH = 2'd2;
   localparam logic [1:0] WAIT_LOW  = 2'd3;

   // Bits needed for a counter that must hold values 0..max_count without wrapping
   function automatic int unsigned cnt_width(input int unsigned max_count);
      if (max_count == 0)
         return 1;
      return $clog2(max_count + 1);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop metastability synchronizer for asynchronous inputs.
// Reused wherever a raw external level crosses into the clock domain.
module sync_2ff #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   // First stage may go metastable; second stage gives it a full cycle to settle
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/button_debouncer.sv
// Debounces a raw push-button into a registered level plus one-cycle
// rise/fall pulses. A new level is accepted once STABLE_CYCLES consecutive
// synchronized samples agree, so btn_level moves STABLE_CYCLES+2 edges
// after btn_in is first sampled at its new value.
// Optional macro DEBOUNCE_AUTO_REPEAT_EN: while the button stays held,
// btn_rise re-pulses every REPEAT_CYCLES cycles (btn_level unaffected).
module button_debouncer
   import debounce_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 4,
   parameter int unsigned REPEAT_CYCLES = 8
) (
   input  logic clock,
   input  logic reset_n,
   input  logic btn_in,
   output logic btn_level,
   output logic btn_rise,
   output logic btn_fall
);

   localparam int unsigned   CW          = cnt_width(STABLE_CYCLES);
   localparam logic [CW-1:0] CNT_ONE     = CW'(1);
   localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES);

   // Illegal parameter values stop elaboration
   if (STABLE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_check
      $error("button_debouncer: STABLE_CYCLES and REPEAT_CYCLES must be >= 1");
   end

   logic          btn_sync;
   logic [1:0]    state;
   logic [1:0]    state_nxt;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic [CW-1:0] cnt_inc;
   logic          level_nxt;
   logic          rise_nxt;
   logic          fall_nxt;
   logic          rep_fire;

   sync_2ff #(
      .WIDTH (1)
   ) u_sync (
      .clock   (clock),
      .reset_n (reset_n),
      .d       (btn_in),
      .q       (btn_sync)
   );

   // cnt counts samples already seen at the candidate level; the sample arriving
   // now is included by comparing cnt+1, so acceptance lands on the edge that
   // delivers the STABLE_CYCLES-th agreeing sample. cnt never exceeds STABLE_CYCLES.
   assign cnt_inc = cnt + CNT_ONE;

   // Next-state, stability counter and output decode
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      level_nxt = btn_level;
      rise_nxt  = 1'b0;
      fall_nxt  = 1'b0;
      case (state)
         IDLE_LOW: begin
            cnt_nxt   = '0;
            level_nxt = 1'b0;
            if (btn_sync) begin
               if (CNT_ONE == STABLE_LAST) begin
                  state_nxt = IDLE_HIGH;
                  level_nxt = 1'b1;
                  rise_nxt  = 1'b1;
               end else begin
                  state_nxt = WAIT_HIGH;
                  cnt_nxt   = CNT_ONE;
               end
            end
         end
         WAIT_HIGH: begin
            if (!btn_sync) begin
               state_nxt = IDLE_LOW;
               cnt_nxt   = '0;
            end else if (cnt_inc == STABLE_LAST) begin
               state_nxt = IDLE_HIGH;
               cnt_nxt   = '0;
               level_nxt = 1'b1;
               rise_nxt  = 1'b1;
            end else begin
               cnt_nxt = cnt_inc;
            end
         end
         IDLE_HIGH: begin
            cnt_nxt   = '0;
            level_nxt = 1'b1;
            if (!btn_sync) begin
               if (CNT_ONE == STABLE_LAST) begin
                  state_nxt = IDLE_LOW;
                  level_nxt = 1'b0;
                  fall_nxt  = 1'b1;
               end else begin
                  state_nxt = WAIT_LOW;
                  cnt_nxt   = CNT_ONE;
               end
            end
         end
         WAIT_LOW: begin
            if (btn_sync) begin
               state_nxt = IDLE_HIGH;
               cnt_nxt   = '0;
            end else if (cnt_inc == STABLE_LAST) begin
               state_nxt = IDLE_LOW;
               cnt_nxt   = '0;
               level_nxt = 1'b0;
               fall_nxt  = 1'b1;
            end else begin
               cnt_nxt = cnt_inc;
            end
         end
         default: begin
            state_nxt = IDLE_LOW;
            cnt_nxt   = '0;
            level_nxt = 1'b0;
         end
      endcase
   end

`ifdef DEBOUNCE_AUTO_REPEAT_EN
   localparam int unsigned   RW       = cnt_width(REPEAT_CYCLES);
   localparam logic [RW-1:0] REP_ONE  = RW'(1);
   localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

   logic [RW-1:0] rep;
   logic [RW-1:0] rep_nxt;

   // Repeat timer runs only while held in IDLE_HIGH; any other state clears it,
   // so it restarts from 0 on every entry and stops as soon as WAIT_LOW is entered
   always_comb begin
      rep_nxt  = '0;
      rep_fire = 1'b0;
      if (state == IDLE_HIGH && btn_sync) begin
         if (rep == REP_LAST) begin
            rep_fire = 1'b1;
         end else begin
            rep_nxt = rep + REP_ONE;
         end
      end
   end

   // Repeat timer register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rep <= '0;
      end else begin
         rep <= rep_nxt;
      end
   end
`else
   assign rep_fire = 1'b0;
`endif

   // FSM, counter and registered outputs
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE_LOW;
         cnt       <= '0;
         btn_level <= 1'b0;
         btn_rise  <= 1'b0;
         btn_fall  <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         btn_level <= level_nxt;
         btn_rise  <= rise_nxt | rep_fire;
         btn_fall  <= fall_nxt;
      end
   end

endmodule
